gpio_atr_sequencer: RTL and testbench

GPIO_ATR_SEQUENCER -- requirements
Module: gpio_atr_sequencer

---
 rtl/gpio_atr_pkg.sv | 32 +++
 rtl/gpio_atr_sequencer_if.sv | 11 +
 rtl/gpio_atr_regs.sv | 82 ++++++++
 rtl/gpio_atr_sequencer.sv | 102 ++++++++++
 tb/tb_gpio_atr_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_atr_pkg.sv
// Shared definitions for the GPIO ATR sequencer: state encoding, register
// offsets within the settings window, and the width of the HOLD register.
package gpio_atr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_TX   = 3'd2,
    ST_FDX  = 3'd3,
    ST_HOLD = 3'd4
  } atr_state_e;

  localparam logic [7:0] REG_IDLE   = 8'd0;
  localparam logic [7:0] REG_RX     = 8'd1;
  localparam logic [7:0] REG_TX     = 8'd2;
  localparam logic [7:0] REG_FDX    = 8'd3;
  localparam logic [7:0] REG_DDR    = 8'd4;
  localparam logic [7:0] REG_MANUAL = 8'd5;
  localparam logic [7:0] REG_HOLD   = 8'd6;

  localparam int HOLD_W = 16;

  function automatic atr_state_e state_from_pins(input logic tx_en, input logic rx_en);
    case ({tx_en, rx_en})
      2'b01:   return ST_RX;
      2'b10:   return ST_TX;
      2'b11:   return ST_FDX;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_atr_sequencer_if.sv
// Settings write bus: one-cycle strobe with an 8-bit address and 32-bit data.
interface gpio_atr_sequencer_if;

  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  modport master (output set_stb, output set_addr, output set_data);
  modport slave  (input  set_stb, input  set_addr, input  set_data);

endinterface

// File: rtl/gpio_atr_regs.sv
// Settings-bus decode and register file for the ATR pattern, direction,
// manual-mask and hold-length registers.
module gpio_atr_regs
  import gpio_atr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BASE  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  gpio_atr_sequencer_if.slave       set_bus,
  output logic [WIDTH-1:0]          idle_reg,
  output logic [WIDTH-1:0]          rx_reg,
  output logic [WIDTH-1:0]          tx_reg,
  output logic [WIDTH-1:0]          fdx_reg,
  output logic [WIDTH-1:0]          ddr_reg,
  output logic [WIDTH-1:0]          manual_reg,
  output logic [HOLD_W-1:0]         hold_reg
);

  localparam logic [7:0] ADDR_BASE = 8'(BASE);

  logic [7:0]        offset;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  idle_d, rx_d, tx_d, fdx_d, ddr_d, manual_d;
  logic [WIDTH-1:0]  idle_q, rx_q, tx_q, fdx_q, ddr_q, manual_q;
  logic [HOLD_W-1:0] hold_d, hold_q;

  assign offset = set_bus.set_addr - ADDR_BASE;
  assign wdata  = set_bus.set_data[WIDTH-1:0];

  always_comb begin
    idle_d   = idle_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    fdx_d    = fdx_q;
    ddr_d    = ddr_q;
    manual_d = manual_q;
    hold_d   = hold_q;
    if (set_bus.set_stb) begin
      case (offset)
        REG_IDLE:   idle_d   = wdata;
        REG_RX:     rx_d     = wdata;
        REG_TX:     tx_d     = wdata;
        REG_FDX:    fdx_d    = wdata;
        REG_DDR:    ddr_d    = wdata;
        REG_MANUAL: manual_d = wdata;
        REG_HOLD:   hold_d   = set_bus.set_data[HOLD_W-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q   <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      fdx_q    <= '0;
      ddr_q    <= '0;
      manual_q <= '0;
      hold_q   <= '0;
    end else begin
      idle_q   <= idle_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      fdx_q    <= fdx_d;
      ddr_q    <= ddr_d;
      manual_q <= manual_d;
      hold_q   <= hold_d;
    end
  end

  assign idle_reg   = idle_q;
  assign rx_reg     = rx_q;
  assign tx_reg     = tx_q;
  assign fdx_reg    = fdx_q;
  assign ddr_reg    = ddr_q;
  assign manual_reg = manual_q;
  assign hold_reg   = hold_q;

endmodule

// File: rtl/gpio_atr_sequencer.sv
// Automatic transmit/receive GPIO sequencer: picks a pin pattern from the
// radio's rx/tx activity, optionally holding the TX pattern after tx ends.
module gpio_atr_sequencer
  import gpio_atr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BASE  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  gpio_atr_sequencer_if.slave  set_bus,
  input  logic                 rx_en,
  input  logic                 tx_en,
  input  logic [WIDTH-1:0]     gpio_in,
  output logic [WIDTH-1:0]     gpio_out,
  output logic [WIDTH-1:0]     gpio_ddr,
  output logic [WIDTH-1:0]     rb_data,
  output logic [2:0]           atr_state
);

  logic [WIDTH-1:0]  idle_reg, rx_reg, tx_reg, fdx_reg, ddr_reg, manual_reg;
  logic [HOLD_W-1:0] hold_reg;

  gpio_atr_regs #(.WIDTH(WIDTH), .BASE(BASE)) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_bus    (set_bus),
    .idle_reg   (idle_reg),
    .rx_reg     (rx_reg),
    .tx_reg     (tx_reg),
    .fdx_reg    (fdx_reg),
    .ddr_reg    (ddr_reg),
    .manual_reg (manual_reg),
    .hold_reg   (hold_reg)
  );

  atr_state_e        state_d, state_q;
  logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
  logic [WIDTH-1:0]  hold_pat_d, hold_pat_q;
  logic [WIDTH-1:0]  gpio_out_d, gpio_out_q;
  logic [WIDTH-1:0]  gpio_ddr_q, rb_data_q;
  logic [WIDTH-1:0]  sel_pat;

  // HOLD snapshots the active TX/FDX pattern value so later pattern writes
  // cannot disturb the tail; a tx_en reassertion or count==1 leaves it.
  always_comb begin
    state_d    = state_from_pins(tx_en, rx_en);
    hold_cnt_d = hold_cnt_q;
    hold_pat_d = hold_pat_q;
    case (state_q)
      ST_TX, ST_FDX: begin
        if (!tx_en && (hold_reg != '0)) begin
          state_d    = ST_HOLD;
          hold_cnt_d = hold_reg;
          hold_pat_d = (state_q == ST_TX) ? tx_reg : fdx_reg;
        end
      end
      ST_HOLD: begin
        if (!tx_en && (hold_cnt_q != HOLD_W'(1))) begin
          state_d    = ST_HOLD;
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_RX:   sel_pat = rx_reg;
      ST_TX:   sel_pat = tx_reg;
      ST_FDX:  sel_pat = fdx_reg;
      ST_HOLD: sel_pat = hold_pat_q;
      default: sel_pat = idle_reg;
    endcase
    gpio_out_d = (manual_reg & idle_reg) | (~manual_reg & sel_pat);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      hold_pat_q <= '0;
      gpio_out_q <= '0;
      gpio_ddr_q <= '0;
      rb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      hold_pat_q <= hold_pat_d;
      gpio_out_q <= gpio_out_d;
      gpio_ddr_q <= ddr_reg;
      rb_data_q  <= gpio_in;
    end
  end

  assign gpio_out  = gpio_out_q;
  assign gpio_ddr  = gpio_ddr_q;
  assign rb_data   = rb_data_q;
  assign atr_state = state_q;

endmodule

// File: tb/tb_gpio_atr_sequencer.sv
// Directed self-checking bench for gpio_atr_sequencer: register decode,
// state sequencing, HOLD tail behaviour, manual mask and async reset.
module tb_gpio_atr_sequencer;

  localparam int         WIDTH = 8;
  localparam logic [7:0] BASE  = 8'h10;

  logic             clk;
  logic             reset_n;
  logic             rx_en;
  logic             tx_en;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_ddr;
  logic [WIDTH-1:0] rb_data;
  logic [2:0]       atr_state;

  int checks = 0;
  int errors = 0;

  gpio_atr_sequencer_if bus ();

  gpio_atr_sequencer #(.WIDTH(WIDTH), .BASE(int'(BASE))) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_bus   (bus.slave),
    .rx_en     (rx_en),
    .tx_en     (tx_en),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_ddr  (gpio_ddr),
    .rb_data   (rb_data),
    .atr_state (atr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tx, input logic rx);
    tx_en = tx;
    rx_en = rx;
    waitCycle();
  endtask

  task automatic writeAddr(input logic [7:0] addr, input logic [31:0] data);
    bus.set_stb  = 1'b1;
    bus.set_addr = addr;
    bus.set_data = data;
    waitCycle();
    bus.set_stb  = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] offset, input logic [31:0] data);
    writeAddr(BASE + offset, data);
  endtask

  initial begin
    reset_n      = 1'b0;
    rx_en        = 1'b0;
    tx_en        = 1'b0;
    gpio_in      = 8'hA5;
    bus.set_stb  = 1'b0;
    bus.set_addr = 8'h00;
    bus.set_data = 32'h0;

    waitCycle();
    waitCycle();
    checkOutput("rst_state", atr_state, 3'd0);
    checkOutput("rst_out", gpio_out, 8'h00);
    checkOutput("rst_ddr", gpio_ddr, 8'h00);
    checkOutput("rst_rb", rb_data, 8'h00);

    @(negedge clk);
    reset_n = 1'b1;
    waitCycle();

    writeReg(8'd0, 32'h1);
    writeReg(8'd1, 32'h2);
    writeReg(8'd2, 32'h4);
    writeReg(8'd3, 32'h8);
    writeAddr(8'h04, 32'hFF);
    writeReg(8'd4, 32'h1234_560F);
    checkOutput("ddr_lag", gpio_ddr, 8'h00);
    waitCycle();
    checkOutput("ddr_value", gpio_ddr, 8'h0F);
    checkOutput("idle_out", gpio_out, 8'h01);
    checkOutput("rb_first", rb_data, 8'hA5);
    gpio_in = 8'h3C;
    checkOutput("rb_hold", rb_data, 8'hA5);
    waitCycle();
    checkOutput("rb_update", rb_data, 8'h3C);

    // rx_en only: state at edge N, pattern at N+1
    applyStimulus(1'b0, 1'b1);
    checkOutput("rx_state", atr_state, 3'd1);
    checkOutput("rx_out_lat", gpio_out, 8'h01);
    waitCycle();
    checkOutput("rx_out", gpio_out, 8'h02);
    checkOutput("rx_ddr", gpio_ddr, 8'h0F);

    // HOLD=3 tail after TX; a HOLD rewrite mid-tail must not reload the count
    writeReg(8'd6, 32'hFFFF_0003);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tx_state", atr_state, 3'd2);
    waitCycle();
    checkOutput("tx_out", gpio_out, 8'h04);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold1_state", atr_state, 3'd4);
    checkOutput("hold1_out", gpio_out, 8'h04);
    writeReg(8'd6, 32'h5);
    checkOutput("hold2_state", atr_state, 3'd4);
    checkOutput("hold2_out", gpio_out, 8'h04);
    waitCycle();
    checkOutput("hold3_state", atr_state, 3'd4);
    checkOutput("hold3_out", gpio_out, 8'h04);
    waitCycle();
    checkOutput("hold_exit_state", atr_state, 3'd0);
    checkOutput("hold_exit_out", gpio_out, 8'h04);
    waitCycle();
    checkOutput("hold_idle_out", gpio_out, 8'h01);

    // HOLD=5, tx_en returns during the tail: straight back to TX
    applyStimulus(1'b1, 1'b0);
    waitCycle();
    checkOutput("retx_pre_out", gpio_out, 8'h04);
    applyStimulus(1'b0, 1'b0);
    checkOutput("retx_h1_state", atr_state, 3'd4);
    checkOutput("retx_h1_out", gpio_out, 8'h04);
    waitCycle();
    checkOutput("retx_h2_state", atr_state, 3'd4);
    checkOutput("retx_h2_out", gpio_out, 8'h04);
    applyStimulus(1'b1, 1'b0);
    checkOutput("retx_state", atr_state, 3'd2);
    checkOutput("retx_out", gpio_out, 8'h04);
    waitCycle();
    checkOutput("retx_out2", gpio_out, 8'h04);

    // HOLD=0: no tail cycle at all
    writeReg(8'd6, 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("nohold_state", atr_state, 3'd0);

    // FDX tail with HOLD=2, exits to RX since rx_en stays high
    writeReg(8'd6, 32'h2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("fdx_state", atr_state, 3'd3);
    waitCycle();
    checkOutput("fdx_out", gpio_out, 8'h08);
    applyStimulus(1'b0, 1'b1);
    checkOutput("fdxh1_state", atr_state, 3'd4);
    waitCycle();
    checkOutput("fdxh2_state", atr_state, 3'd4);
    checkOutput("fdxh2_out", gpio_out, 8'h08);
    waitCycle();
    checkOutput("fdxh_exit_state", atr_state, 3'd1);
    waitCycle();
    checkOutput("fdxh_exit_out", gpio_out, 8'h02);

    // Manual mask forces IDLE bits regardless of state
    writeReg(8'd6, 32'h0);
    writeReg(8'd2, 32'hC);
    writeReg(8'd5, 32'h3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("man_tx_state", atr_state, 3'd2);
    waitCycle();
    checkOutput("man_tx_out", gpio_out, 8'h0D);
    applyStimulus(1'b0, 1'b1);
    waitCycle();
    checkOutput("man_rx_out", gpio_out, 8'h01);

    // Asynchronous reset in the middle of a HOLD tail, mid-cycle
    writeReg(8'd5, 32'h0);
    writeReg(8'd6, 32'h5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitCycle();
    checkOutput("prerst_state", atr_state, 3'd4);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_state", atr_state, 3'd0);
    checkOutput("arst_out", gpio_out, 8'h00);
    checkOutput("arst_ddr", gpio_ddr, 8'h00);
    checkOutput("arst_rb", rb_data, 8'h00);
    tx_en = 1'b1;
    waitCycle();
    checkOutput("rst_held_state", atr_state, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;
    waitCycle();
    checkOutput("post_first_state", atr_state, 3'd2);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_nohold_state", atr_state, 3'd0);
    writeAddr(BASE + 8'd7, 32'hFF);
    waitCycle();
    checkOutput("post_bad_out", gpio_out, 8'h00);
    checkOutput("post_bad_ddr", gpio_ddr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
